// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  localparam logic [3:0] KEY_EQ  = 4'd10;
  localparam logic [3:0] KEY_CLR = 4'd11;
  localparam logic [3:0] KEY_ADD = 4'd12;
  localparam logic [3:0] KEY_SUB = 4'd13;
  localparam logic [3:0] KEY_MUL = 4'd14;
  localparam logic [3:0] KEY_DIV = 4'd15;

  localparam logic [3:0] ROW_RST  = 4'b1110;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Exactly one line pulled low.
  function automatic logic one_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  // Position of the low bit in a one-hot-low vector.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!v[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic [3:0] rot_row(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the key-code output toward the calculator core.
interface keypad_if;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] data;
  logic       flag;

  modport master (input key_col, output key_row, output data, output flag);
  modport slave  (output key_col, input key_row, input data, input flag);
endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous column lines; idles high.
module key_sync
  import keypad_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_1khz,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] meta;

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      meta <= {W{1'b1}};
      dout <= {W{1'b1}};
    end else begin
      meta <= din;
      dout <= meta;
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with press/release debounce and a one-clock flag per key.
// Optional auto-repeat while held: define KEY_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL    = 4,
  parameter int DEBOUNCE_CYC = 20
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYC = 500,
  parameter int REPEAT_CYC       = 100
`endif
) (
  input logic      clk_1khz,
  input logic      rst,
  keypad_if.master kp
);
  localparam int CNT_MAX = (ROW_DWELL > DEBOUNCE_CYC) ? ROW_DWELL : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(ROW_DWELL - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       row_q, row_n;
  logic [3:0]       lcol, lcol_n;
  logic [3:0]       data_q, data_n;
  logic             flag_q, flag_n;
  logic [3:0]       col_s;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_CYC) ? REPEAT_DELAY_CYC : REPEAT_CYC;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_cnt, rep_cnt_n, rep_tgt;
  logic             rep_first, rep_first_n;
  logic             rep_on, rep_on_n;
  assign rep_tgt = rep_first ? REP_W'(REPEAT_DELAY_CYC - 1) : REP_W'(REPEAT_CYC - 1);
`endif

  key_sync #(.W(4)) u_sync (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .din      (kp.key_col),
    .dout     (col_s)
  );

  assign kp.key_row = row_q;
  assign kp.data    = data_q;
  assign kp.flag    = flag_q;

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      state  <= SCAN;
      cnt    <= '0;
      row_q  <= ROW_RST;
      lcol   <= COL_IDLE;
      data_q <= 4'd0;
      flag_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b0;
      rep_on    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      row_q  <= row_n;
      lcol   <= lcol_n;
      data_q <= data_n;
      flag_q <= flag_n;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= rep_cnt_n;
      rep_first <= rep_first_n;
      rep_on    <= rep_on_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    row_n   = row_q;
    lcol_n  = lcol;
    data_n  = data_q;
    flag_n  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_n   = rep_cnt;
    rep_first_n = rep_first;
    rep_on_n    = rep_on;
`endif
    unique case (state)
      SCAN: begin
        // Decide only on the last dwell clock so the synchronizer has settled.
        if (cnt == DWELL_LAST) begin
          cnt_n = '0;
          if (one_low(col_s)) begin
            state_n = PRESS_DB;
            lcol_n  = col_s;
          end else begin
            row_n = rot_row(row_q);
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESS_DB: begin
        if (col_s != lcol) begin
          state_n = SCAN;
          cnt_n   = '0;
          row_n   = rot_row(row_q);
        end else if (cnt == DB_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          flag_n  = 1'b1;
          data_n  = {low_idx(row_q), low_idx(lcol)};
`ifdef KEY_REPEAT_EN
          rep_cnt_n   = '0;
          rep_first_n = 1'b1;
          rep_on_n    = 1'b1;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (col_s == COL_IDLE) begin
          state_n = REL_DB;
          cnt_n   = '0;
        end
`ifdef KEY_REPEAT_EN
        // Repeat stops for good once the column leaves the accepted key.
        if (col_s != lcol) begin
          rep_on_n = 1'b0;
        end else if (rep_on) begin
          if (rep_cnt == rep_tgt) begin
            flag_n      = 1'b1;
            rep_cnt_n   = '0;
            rep_first_n = 1'b0;
          end else begin
            rep_cnt_n = rep_cnt + 1'b1;
          end
        end
`endif
      end
      REL_DB: begin
        if (col_s != COL_IDLE) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = SCAN;
          cnt_n   = '0;
          row_n   = rot_row(row_q);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed keypad scenarios; a monitor scoreboards every flag against queued key codes.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int DWELL   = 4;
  localparam int DB      = 20;
  localparam int LAT_MAX = 2 + 4 * DWELL + DB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_if kp();

  keypad_scan #(.ROW_DWELL(DWELL), .DEBOUNCE_CYC(DB)) dut (
    .clk_1khz (clk),
    .rst      (rst),
    .kp       (kp)
  );

  // Matrix model: a pressed key pulls its column low while its row is driven low.
  logic [15:0] pressed = '0;
  logic [3:0]  col_drv;
  always_comb begin
    col_drv = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[r*4+c] && !kp.key_row[r]) col_drv[c] = 1'b0;
  end
  assign kp.key_col = col_drv;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int flag_cnt = 0, last_flag_cyc = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expected code per flag.
  initial begin
    logic       prev_flag;
    logic [3:0] prev_data;
    prev_flag = 1'b0;
    prev_data = 4'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_flag = 1'b0;
        prev_data = kp.data;
      end else begin
        if (kp.flag) begin
          flag_cnt++;
          last_flag_cyc = cyc;
          chk("flag_width", int'(prev_flag), 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flag: got data %0d with no expected key", kp.data);
          end else begin
            chk("flag_data", kp.data, exp_q.pop_front());
          end
        end else if (kp.data != prev_data) begin
          chk("data_hold", kp.data, prev_data);
        end
        prev_flag = kp.flag;
        prev_data = kp.data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_row_change(output int n, output logic [3:0] v);
    logic [3:0] prev;
    prev = kp.key_row;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (kp.key_row == prev && n < 20);
    v = kp.key_row;
    if (kp.key_row == prev) begin
      checks++;
      errors++;
      $display("FAIL row_timeout: key_row stuck at %b", prev);
    end
  endtask

  initial begin
    int n, f0, t, run, k, n_exp;
    logic [3:0] v;

    tick(3);
    chk("rst_row", kp.key_row, 4'b1110);
    chk("rst_data", kp.data, 0);
    chk("rst_flag", kp.flag, 0);
    rst = 1'b0;

    wait_row_change(n, v);
    chk("rot_first", v, 4'b1101);
    wait_row_change(n, v);
    chk("rot_second", v, 4'b1011);
    chk("rot_dwell", n, DWELL);

    // Key 5 held 60 clocks
    f0 = flag_cnt;
    exp_q.push_back(4'd5);
    pressed[5] = 1'b1;
    t = cyc;
    tick(60);
    chk("k5_count", flag_cnt - f0, 1);
    chk_range("k5_latency", last_flag_cyc - t, DB + 1, LAT_MAX);
    pressed[5] = 1'b0;
    tick(45);
    chk("k5_after_release", flag_cnt - f0, 1);

    // Key 7 bouncing, then stable
    f0 = flag_cnt;
    exp_q.push_back(4'd7);
    for (int i = 0; i < 5; i++) begin
      pressed[7] = (i % 2 == 0);
      t = cyc;
      tick(3);
    end
    tick(40);
    chk("k7_count", flag_cnt - f0, 1);
    chk_range("k7_latency", last_flag_cyc - t, DB + 1, LAT_MAX);
    pressed[7] = 1'b0;
    tick(45);

    // Key 9 too short
    f0 = flag_cnt;
    pressed[9] = 1'b1;
    tick(10);
    pressed[9] = 1'b0;
    tick(45);
    chk("k9_count", flag_cnt - f0, 0);
    wait_row_change(n, v);
    chk_range("k9_scan_resumes", n, 1, DWELL);

    // Two keys on row 3, then one released
    f0 = flag_cnt;
    pressed[12] = 1'b1;
    pressed[14] = 1'b1;
    tick(60);
    chk("multi_count", flag_cnt - f0, 0);
    exp_q.push_back(KEY_MUL);
    pressed[12] = 1'b0;
    t = cyc;
    tick(45);
    chk("k14_count", flag_cnt - f0, 1);
    chk_range("k14_latency", last_flag_cyc - t, DB + 1, LAT_MAX);
    pressed[14] = 1'b0;
    tick(45);

    // Reset while key 0 is being debounced
    f0 = flag_cnt;
    pressed[0] = 1'b1;
    run = 0;
    k = 0;
    while (run < DWELL + 2 && k < 60) begin
      tick(1);
      k++;
      run = (kp.key_row == 4'b1110) ? run + 1 : 0;
    end
    chk("k0_row_frozen", run, DWELL + 2);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_row", kp.key_row, 4'b1110);
    chk("mid_rst_data", kp.data, 0);
    chk("mid_rst_flag", kp.flag, 0);
    chk("mid_rst_no_flag", flag_cnt - f0, 0);
    tick(1);
    rst = 1'b0;
    exp_q.push_back(4'd0);
    t = cyc;
    tick(45);
    chk("k0_count", flag_cnt - f0, 1);
    chk_range("k0_fresh_debounce", last_flag_cyc - t, DB + 1, LAT_MAX);
    pressed[0] = 1'b0;
    tick(45);

    // Key 15 held long
    f0 = flag_cnt;
    exp_q.push_back(KEY_DIV);
`ifdef KEY_REPEAT_EN
    exp_q.push_back(KEY_DIV);
    exp_q.push_back(KEY_DIV);
    exp_q.push_back(KEY_DIV);
    n_exp = 4;
`else
    n_exp = 1;
`endif
    pressed[15] = 1'b1;
    tick(800);
    pressed[15] = 1'b0;
    tick(45);
    chk("k15_count", flag_cnt - f0, n_exp);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
